// File: rtl/car2pol_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : car2pol_axil_slave
// Brief    : AXI4-Lite register file for the car2pol core. Holds MAP,
//            INP_IMAGE and W_ADDR, launches the core via the INP_VALID
//            doorbell with a valid/ready start handshake, and reports
//            pending/done/overrun status.
//            Optional feature macro: C2P_IRQ_EN (adds irq_o and IRQ_ENABLE
//            at offset 0x14).
// Revision : 1.0 - initial release
// ============================================================================
module car2pol_axil_slave #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // AXI4-Lite write address channel
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // AXI4-Lite write data channel
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // AXI4-Lite write response channel
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // AXI4-Lite read address channel
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // AXI4-Lite read data channel
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // Core-side interface
  output logic [DATA_W-1:0]     map_o,
  output logic [DATA_W-1:0]     inp_image_o,
  output logic [DATA_W-1:0]     w_addr_o,
  output logic                  inp_valid_o,
  input  logic                  core_ready_i,
  input  logic                  core_done_i
`ifdef C2P_IRQ_EN
  ,
  output logic                  irq_o
`endif
);

  localparam int c_IDX_W  = ADDR_W - 2;
  localparam int c_STRB_W = DATA_W / 8;

  localparam logic [c_IDX_W-1:0] c_IDX_MAP    = c_IDX_W'(0);
  localparam logic [c_IDX_W-1:0] c_IDX_IMAGE  = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_WADDR  = c_IDX_W'(2);
  localparam logic [c_IDX_W-1:0] c_IDX_START  = c_IDX_W'(3);
  localparam logic [c_IDX_W-1:0] c_IDX_STATUS = c_IDX_W'(4);
  localparam logic [c_IDX_W-1:0] c_IDX_IRQEN  = c_IDX_W'(5);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  // Byte-lane merge of write data into an existing register value
  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0]   old_val,
    input logic [DATA_W-1:0]   new_val,
    input logic [c_STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < c_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Write-channel holding registers and response
  logic                r_aw_held;
  logic [c_IDX_W-1:0]  r_aw_idx;
  logic                r_w_held;
  logic [DATA_W-1:0]   r_w_data;
  logic [c_STRB_W-1:0] r_w_strb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;

  // Read channel
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  // Register file, snapshots and status
  logic [DATA_W-1:0]   r_map;
  logic [DATA_W-1:0]   r_image;
  logic [DATA_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_map_snap;
  logic [DATA_W-1:0]   r_image_snap;
  logic [DATA_W-1:0]   r_waddr_snap;
  logic                r_pending;
  logic                r_done;
  logic                r_overrun;
  logic                r_irq_en;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_do_write;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0]   w_wr_data;
  logic [c_STRB_W-1:0] w_wr_strb;
  logic                w_wr_ok;
  logic                w_start_req;
  logic                w_core_take;
  logic                w_launch;
  logic                w_overrun_set;
  logic                w_status_wr;
  logic                w_clr_done;
  logic                w_clr_ovr;
  logic                w_ar_hs;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_rd_ok;
  logic                w_unused;

  assign s_awready = !r_aw_held && !r_bvalid;
  assign s_wready  = !r_w_held && !r_bvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = !r_rvalid;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  assign map_o       = r_map_snap;
  assign inp_image_o = r_image_snap;
  assign w_addr_o    = r_waddr_snap;
  assign inp_valid_o = r_pending;

  assign w_aw_hs    = s_awvalid && s_awready;
  assign w_w_hs     = s_wvalid && s_wready;
  // The write commits as soon as both halves are either held or arriving now
  assign w_do_write = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_idx   = r_aw_held ? r_aw_idx : s_awaddr[ADDR_W-1:2];
  assign w_wr_data  = r_w_held ? r_w_data : s_wdata;
  assign w_wr_strb  = r_w_held ? r_w_strb : s_wstrb;

  // Start doorbell: a start on the edge the core takes the previous request
  // re-launches instead of counting as an overrun.
  assign w_start_req   = w_do_write && (w_wr_idx == c_IDX_START) && w_wr_data[0] && w_wr_strb[0];
  assign w_core_take   = r_pending && core_ready_i;
  assign w_launch      = w_start_req && (!r_pending || w_core_take);
  assign w_overrun_set = w_start_req && r_pending && !core_ready_i;

  assign w_status_wr = w_do_write && (w_wr_idx == c_IDX_STATUS) && w_wr_strb[0];
  assign w_clr_done  = w_status_wr && w_wr_data[1];
  assign w_clr_ovr   = w_status_wr && w_wr_data[2];

  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_rd_idx = s_araddr[ADDR_W-1:2];

  // Byte-offset address bits are ignored by the decode
  assign w_unused = &{1'b0, s_awaddr[1:0], s_araddr[1:0]};

  // Write-offset decode: which offsets answer OKAY
  always_comb begin
    w_wr_ok = 1'b0;
    case (w_wr_idx)
      c_IDX_MAP, c_IDX_IMAGE, c_IDX_WADDR, c_IDX_START, c_IDX_STATUS: w_wr_ok = 1'b1;
`ifdef C2P_IRQ_EN
      c_IDX_IRQEN: w_wr_ok = 1'b1;
`endif
      default: w_wr_ok = 1'b0;
    endcase
  end

  // Read mux from the current (pre-edge) register contents
  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b1;
    case (w_rd_idx)
      c_IDX_MAP:    w_rd_data = r_map;
      c_IDX_IMAGE:  w_rd_data = r_image;
      c_IDX_WADDR:  w_rd_data = r_waddr;
      c_IDX_START:  w_rd_data[0] = r_pending;
      c_IDX_STATUS: begin
        w_rd_data[0] = r_pending;
        w_rd_data[1] = r_done;
        w_rd_data[2] = r_overrun;
      end
`ifdef C2P_IRQ_EN
      c_IDX_IRQEN:  w_rd_data[0] = r_irq_en;
`endif
      default:      w_rd_ok = 1'b0;
    endcase
  end

  // AW/W holding registers and the write response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
    end else begin
      if (w_do_write) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= s_awaddr[ADDR_W-1:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= s_wdata;
          r_w_strb <= s_wstrb;
        end
        if (r_bvalid && s_bready) r_bvalid <= 1'b0;
      end
    end
  end

  // RW configuration registers with per-byte strobes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_map    <= '0;
      r_image  <= '0;
      r_waddr  <= '0;
      r_irq_en <= 1'b0;
    end else if (w_do_write) begin
      case (w_wr_idx)
        c_IDX_MAP:   r_map   <= f_merge(r_map, w_wr_data, w_wr_strb);
        c_IDX_IMAGE: r_image <= f_merge(r_image, w_wr_data, w_wr_strb);
        c_IDX_WADDR: r_waddr <= f_merge(r_waddr, w_wr_data, w_wr_strb);
`ifdef C2P_IRQ_EN
        c_IDX_IRQEN: if (w_wr_strb[0]) r_irq_en <= w_wr_data[0];
`endif
        default: ;
      endcase
    end
  end

  // Start handshake: pending flag and snapshot capture
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pending    <= 1'b0;
      r_map_snap   <= '0;
      r_image_snap <= '0;
      r_waddr_snap <= '0;
    end else if (w_launch) begin
      r_pending    <= 1'b1;
      r_map_snap   <= r_map;
      r_image_snap <= r_image;
      r_waddr_snap <= r_waddr;
    end else if (w_core_take) begin
      r_pending <= 1'b0;
    end
  end

  // Sticky status bits; a set on the same edge as a clear wins
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= core_done_i   || (r_done && !w_clr_done);
      r_overrun <= w_overrun_set || (r_overrun && !w_clr_ovr);
    end
  end

  // Read data channel: capture on AR handshake, hold until accepted
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
    end else if (r_rvalid && s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

`ifdef C2P_IRQ_EN
  // Level interrupt built only from registered state
  assign irq_o = r_done && r_irq_en;
`endif

endmodule
`default_nettype wire

// File: tb/tb_car2pol_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_car2pol_axil_slave
// Brief    : Directed self-checking bench for car2pol_axil_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_car2pol_axil_slave;

  logic        aclk;
  logic        aresetn;
  logic [4:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [4:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] map_o;
  logic [31:0] inp_image_o;
  logic [31:0] w_addr_o;
  logic        inp_valid_o;
  logic        core_ready_i;
  logic        core_done_i;
`ifdef C2P_IRQ_EN
  logic        irq_o;
`endif

  int n_checks;
  int n_fail;
  int valid_cycles;

  car2pol_axil_slave #(.ADDR_W(5), .DATA_W(32)) u_dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_awaddr     (s_awaddr),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_araddr     (s_araddr),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .map_o        (map_o),
    .inp_image_o  (inp_image_o),
    .w_addr_o     (w_addr_o),
    .inp_valid_o  (inp_valid_o),
    .core_ready_i (core_ready_i),
    .core_done_i  (core_done_i)
`ifdef C2P_IRQ_EN
    ,
    .irq_o        (irq_o)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count cycles with the start request asserted, sampled mid-cycle
  always @(negedge aclk) begin
    if (inp_valid_o === 1'b1) valid_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int  n;
    logic aw_acc;
    logic w_acc;
    s_awaddr  = addr;
    s_wdata   = data;
    s_wstrb   = strb;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    n = 0;
    do begin
      aw_acc = s_awvalid && s_awready;
      w_acc  = s_wvalid && s_wready;
      @(posedge aclk); #1;
      if (aw_acc) s_awvalid = 1'b0;
      if (w_acc)  s_wvalid  = 1'b0;
      n++;
    end while (!s_bvalid && n < 20);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    if (!s_bvalid) begin
      check_eq("wr_timeout", 32'd0, 32'd1);
      resp = 2'b11;
      return;
    end
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    n = 0;
    do begin
      @(posedge aclk); #1;
      n++;
    end while (!s_rvalid && n < 20);
    s_arvalid = 1'b0;
    if (!s_rvalid) begin
      check_eq("rd_timeout", 32'd0, 32'd1);
      data = '0;
      resp = 2'b11;
      return;
    end
    data = s_rdata;
    resp = s_rresp;
    s_rready = 1'b1;
    @(posedge aclk); #1;
    s_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [1:0]  bsp;
    int          base;
    logic [4:0]  rst_addrs [5];

    n_checks = 0; n_fail = 0; valid_cycles = 0;
    aresetn = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    core_ready_i = 1'b0; core_done_i = 1'b0;

    // Reset state: every register reads zero
    repeat (16) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("rst_inp_valid", {31'b0, inp_valid_o}, 32'd0);
    check_eq("rst_map_o", map_o, 32'd0);
    rst_addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
    foreach (rst_addrs[i]) begin
      axi_read(rst_addrs[i], rd, rsp);
      check_eq($sformatf("rst_rdata_%0h", rst_addrs[i]), rd, 32'd0);
      check_eq($sformatf("rst_rresp_%0h", rst_addrs[i]), {30'b0, rsp}, 32'd0);
    end

    // Basic launch with the core ready: one-cycle start request
    core_ready_i = 1'b1;
    axi_write(5'h00, 32'd6, 4'hF, bsp);
    axi_write(5'h00, 32'd7, 4'hF, bsp);
    axi_write(5'h04, 32'd5, 4'hF, bsp);
    axi_write(5'h08, 32'd4, 4'hF, bsp);
    base = valid_cycles;
    axi_write(5'h0C, 32'd1, 4'hF, bsp);
    check_eq("t2_bresp", {30'b0, bsp}, 32'd0);
    repeat (3) @(posedge aclk); #1;
    check_eq("t2_valid_cycles", valid_cycles - base, 32'd1);
    check_eq("t2_inp_valid_low", {31'b0, inp_valid_o}, 32'd0);
    check_eq("t2_map_o", map_o, 32'd7);
    check_eq("t2_inp_image_o", inp_image_o, 32'd5);
    check_eq("t2_w_addr_o", w_addr_o, 32'd4);

    // Overrun while pending, snapshots frozen
    core_ready_i = 1'b0;
    axi_write(5'h0C, 32'd1, 4'hF, bsp);
    axi_write(5'h0C, 32'd1, 4'hF, bsp);
    check_eq("t3_overrun_bresp", {30'b0, bsp}, 32'd0);
    axi_write(5'h00, 32'd9, 4'hF, bsp);
    axi_read(5'h10, rd, rsp);
    check_eq("t3_status", rd, 32'h5);
    axi_read(5'h0C, rd, rsp);
    check_eq("t3_inp_valid_reg", rd, 32'h1);
    check_eq("t3_map_o_frozen", map_o, 32'd7);
    core_ready_i = 1'b1;
    @(posedge aclk); #1;
    core_ready_i = 1'b0;
    check_eq("t3_pending_clear", {31'b0, inp_valid_o}, 32'd0);
    axi_read(5'h10, rd, rsp);
    check_eq("t3_status_after", rd, 32'h4);
    axi_write(5'h10, 32'h4, 4'hF, bsp);
    axi_read(5'h10, rd, rsp);
    check_eq("t3_overrun_w1c", rd, 32'h0);

    // W three cycles ahead of AW; response back-pressured four cycles
    s_wdata = 32'h11; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_wvalid = 1'b0;
    check_eq("t4_wready_held", {31'b0, s_wready}, 32'd0);
    repeat (2) @(posedge aclk); #1;
    check_eq("t4_no_early_b", {31'b0, s_bvalid}, 32'd0);
    s_awaddr = 5'h08; s_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
    check_eq("t4_bvalid", {31'b0, s_bvalid}, 32'd1);
    s_awaddr = 5'h08; s_wdata = 32'h22; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("t4_stall_rdy_%0d", c), {30'b0, s_awready, s_wready}, 32'd0);
      check_eq($sformatf("t4_stall_bv_%0d", c), {31'b0, s_bvalid}, 32'd1);
      @(posedge aclk); #1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    check_eq("t4_bvalid_drop", {31'b0, s_bvalid}, 32'd0);
    check_eq("t4_ready_back", {30'b0, s_awready, s_wready}, 32'd3);
    axi_read(5'h08, rd, rsp);
    check_eq("t4_waddr_value", rd, 32'h11);

    // Byte strobes and unmapped offsets
    axi_write(5'h04, 32'h0, 4'hF, bsp);
    axi_write(5'h04, 32'hAABBCCDD, 4'h2, bsp);
    axi_read(5'h04, rd, rsp);
    check_eq("t5_strobe", rd, 32'h0000CC00);
    axi_read(5'h1C, rd, rsp);
    check_eq("t5_unmapped_rresp", {30'b0, rsp}, 32'h2);
    check_eq("t5_unmapped_rdata", rd, 32'h0);
    axi_write(5'h1C, 32'h1234, 4'hF, bsp);
    check_eq("t5_unmapped_bresp", {30'b0, bsp}, 32'h2);

    // Read and write to the same register in the same cycle: old value
    s_awaddr = 5'h00; s_wdata = 32'h33; s_wstrb = 4'hF; s_araddr = 5'h00;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check_eq("rw_same_rvalid", {31'b0, s_rvalid}, 32'd1);
    check_eq("rw_same_old", s_rdata, 32'd9);
    s_bready = 1'b1; s_rready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0; s_rready = 1'b0;
    axi_read(5'h00, rd, rsp);
    check_eq("rw_same_new", rd, 32'h33);

    // Start on the clearing edge re-launches with fresh snapshots
    axi_write(5'h0C, 32'd1, 4'hF, bsp);
    check_eq("relaunch_first_map", map_o, 32'h33);
    axi_write(5'h00, 32'h66, 4'hF, bsp);
    s_awaddr = 5'h0C; s_wdata = 32'd1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; core_ready_i = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_eq("relaunch_pending", {31'b0, inp_valid_o}, 32'd1);
    check_eq("relaunch_map", map_o, 32'h66);
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0; core_ready_i = 1'b0;
    check_eq("relaunch_taken", {31'b0, inp_valid_o}, 32'd0);
    axi_read(5'h10, rd, rsp);
    check_eq("relaunch_no_overrun", rd, 32'h0);

`ifdef C2P_IRQ_EN
    axi_write(5'h14, 32'd1, 4'hF, bsp);
    check_eq("irq_en_bresp", {30'b0, bsp}, 32'd0);
`else
    axi_read(5'h14, rd, rsp);
    check_eq("irqen_unmapped", {30'b0, rsp}, 32'h2);
`endif

    // Done status: set, then set-vs-clear collision, then clear
    core_done_i = 1'b1;
    @(posedge aclk); #1;
    core_done_i = 1'b0;
    axi_read(5'h10, rd, rsp);
    check_eq("t6_done_set", rd, 32'h2);
`ifdef C2P_IRQ_EN
    check_eq("t6_irq_high", {31'b0, irq_o}, 32'd1);
`endif
    s_awaddr = 5'h10; s_wdata = 32'h2; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; core_done_i = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; core_done_i = 1'b0;
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    axi_read(5'h10, rd, rsp);
    check_eq("t6_set_wins", rd, 32'h2);
    axi_write(5'h10, 32'h2, 4'hF, bsp);
    axi_read(5'h10, rd, rsp);
    check_eq("t6_done_w1c", rd, 32'h0);
`ifdef C2P_IRQ_EN
    check_eq("t6_irq_low", {31'b0, irq_o}, 32'd0);
`endif

    // Asynchronous reset mid-transaction drops bvalid and the start request
    s_awaddr = 5'h0C; s_wdata = 32'd1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_eq("arst_pre_bvalid", {31'b0, s_bvalid}, 32'd1);
    check_eq("arst_pre_pending", {31'b0, inp_valid_o}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check_eq("arst_bvalid", {31'b0, s_bvalid}, 32'd0);
    check_eq("arst_pending", {31'b0, inp_valid_o}, 32'd0);
    check_eq("arst_map_o", map_o, 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
